// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-unit types: FSM encoding, reset vector
// and the RV32 opcode constants the decoder keys on.
package inst_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] HALT_INST    = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [6:0] opcode_of(
    input logic [31:0] w
  );
    return w[6:0];
  endfunction

  function automatic logic [2:0] funct3_of(
    input logic [31:0] w
  );
    return w[14:12];
  endfunction

  function automatic logic [6:0] funct7_of(
    input logic [31:0] w
  );
    return w[31:25];
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, decoder
// handshake, redirect/halt control and delivery count.
interface inst_fetch_unit_if #(
  parameter int XLEN = 32
);
  import inst_fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt_req;
  logic [31:0]     fetch_count;

  modport master (
    output imem_req_valid,
    output imem_addr,
    output inst_valid,
    output inst,
    output inst_pc,
    output fetch_count,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  fetch_count,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output inst_ready,
    output redirect_valid,
    output redirect_pc,
    output halt_req
  );

endinterface

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch FSM with Moore
// outputs, redirect kill tracking and sticky halt.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            kill_q, kill_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    kill_d  = kill_q;
    cnt_d   = cnt_q;
    if (bus.halt_req) begin
      state_d = ST_HALT;
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (bus.redirect_valid) pc_d = redir_pc;
          // an accepted stale request must be dropped on return
          if (bus.imem_req_ready) begin
            state_d = ST_WAIT;
            kill_d  = bus.redirect_valid;
          end
        end
        ST_WAIT: begin
          if (bus.redirect_valid) begin
            pc_d = redir_pc;
            if (bus.imem_rsp_valid) begin
              state_d = ST_REQ;
              kill_d  = 1'b0;
            end else begin
              kill_d  = 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (kill_q) begin
              state_d = ST_REQ;
              kill_d  = 1'b0;
            end else begin
              buf_d   = bus.imem_rsp_data;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.redirect_valid) begin
            pc_d    = redir_pc;
            state_d = ST_REQ;
          end else if (bus.inst_ready) begin
            pc_d    = pc_q + XLEN'(4);
            cnt_d   = cnt_q + 32'd1;
            state_d = ST_REQ;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.imem_req_valid = (state_q == ST_REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = (state_q == ST_HOLD);
  assign bus.inst           = buf_q;
  assign bus.inst_pc        = pc_q;
  assign bus.fetch_count    = cnt_q;

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter XLEN, default 32, meaning the PC, address and instruction width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1, meaning a fetch request is presented.
REQ-006 SHALL have port imem_req_ready, input, 1, meaning memory accepts the request this cycle.
REQ-007 SHALL have port imem_addr, output, XLEN, the fetch address (the current PC).
REQ-008 SHALL have port imem_rsp_valid, input, 1, meaning the fetched word is valid.
REQ-009 SHALL have port imem_rsp_data, input, XLEN, the fetched instruction word.
REQ-010 SHALL have port inst_valid, output, 1, meaning an instruction is offered to the decoder.
REQ-011 SHALL have port inst_ready, input, 1, meaning the decoder consumes the instruction.
REQ-012 SHALL have port inst, output, XLEN, the instruction (opcode/funct3/funct7 fields for the decoder).
REQ-013 SHALL have port inst_pc, output, XLEN, the PC of inst.
REQ-014 SHALL have port redirect_valid, input, 1, meaning a taken branch/jump from execute.
REQ-015 SHALL have port redirect_pc, input, XLEN, the branch/jump target.
REQ-016 SHALL have port halt_req, input, 1, meaning the decoder flagged the all-zero halt instruction.
REQ-017 SHALL have port fetch_count, output, 32, the count of instructions delivered.

Function
REQ-018 SHALL implement the FSM states REQ, WAIT, HOLD and HALT.
REQ-019 In REQ: imem_req_valid=1 and imem_addr=pc; on imem_req_ready, SHALL go to WAIT.
REQ-020 In WAIT: on imem_rsp_valid, SHALL latch imem_rsp_data into the buffer and go to HOLD; if the kill flag is set, SHALL discard the data, clear kill and go to REQ.
REQ-021 In HOLD: inst_valid=1, inst=buffer, inst_pc=pc; on inst_ready, SHALL set pc<=pc+4, increment fetch_count and go to REQ (one transfer per handshake).
REQ-022 Outputs SHALL be Moore (state-registered): at most one outstanding memory request; fetch-to-deliver latency SHALL be ≥3 cycles with zero-wait memory.
REQ-023 pc+4 and fetch_count SHALL wrap modulo 2^32; redirect_pc[1:0] SHALL be forced to 0.
REQ-024 Redirect in REQ: pc<=redirect_pc and stay in REQ; if imem_req_ready is high the same cycle, the old request is accepted, kill is set and the FSM goes to WAIT. The memory side tolerates withdrawal of an unaccepted request.
REQ-025 Redirect in WAIT: pc<=redirect_pc and set kill; a response arriving the same cycle SHALL be discarded and the FSM go to REQ.
REQ-026 Redirect in HOLD: SHALL take priority over inst_ready; buffer dropped, fetch_count unchanged, pc<=redirect_pc, go to REQ.
REQ-027 halt_req high in any state SHALL force HALT next cycle; halt has priority over redirect. In HALT all valids are 0 and pc and count are frozen until rst.
REQ-028 inst and inst_pc SHALL be stable while inst_valid=1 and inst_ready=0.

Reset
REQ-029 On rst: state=REQ, pc=RESET_PC, kill=0, buffer=0, fetch_count=0, inst_valid=0, imem_req_valid=1 after release, inst=0, inst_pc=RESET_PC.
REQ-030 rst asserted mid-transaction SHALL abandon it immediately; a late imem_rsp_valid in REQ SHALL be ignored.

Structure
REQ-031 FSM state encodings and RESET_PC default SHALL live in the shared TYPES definitions alongside the opcode constants.
REQ-032 The design SHALL be a single module with no sub-module; the pc register SHALL be a plain always block.

Verification
REQ-033 Reset, zero-wait memory returning 32'h00100093 -> inst_valid with inst=32'h00100093 and inst_pc=32'h8000_0000; after ready, next imem_addr=32'h8000_0004 and fetch_count=1.
REQ-034 inst_ready low for 5 cycles in HOLD -> inst and inst_pc held constant; no new imem request issued.
REQ-035 Redirect to 32'h8000_0103 during WAIT, response 32'hDEADBEEF arrives -> word discarded; next imem_addr=32'h8000_0100.
REQ-036 Redirect and inst_ready in the same HOLD cycle -> fetch_count unchanged; next fetch at the target.
REQ-037 halt_req and redirect_valid asserted together -> HALT; imem_req_valid=0 and inst_valid=0 permanently until rst.
REQ-038 pc=32'hFFFF_FFFC delivered -> next imem_addr=32'h0000_0000.
